// File: rtl/bus_pkg.sv
// ============================================================================
// Module  : bus_pkg
// Brief   : Shared types and constants for the fetch/execute bus arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ_F  = 3'd1,
        ST_REQ_E  = 3'd2,
        ST_WAIT_F = 3'd3,
        ST_WAIT_E = 3'd4
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        is_exec;
    } bus_req_t;

    localparam logic [3:0] BUS_WSTRB_ALL = 4'hF;

endpackage

`default_nettype wire

// File: rtl/bus_timeout_counter.sv
// ============================================================================
// Module  : bus_timeout_counter
// Brief   : Counts response-wait cycles; flags the last allowed wait cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [15:0] c_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count_q;

    always_ff @(posedge clock) begin
        if (reset || clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + 16'd1;
        end
    end

    // Asserted during the TIMEOUT_CYCLES-th consecutive enabled cycle.
    assign expired_o = enable_i && (count_q == c_LAST);

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module  : bus_arbiter
// Brief   : Shares one bus master port between fetch and execute; execute has
//           priority, bounded by a streak limit. Optional macro BUS_TIMEOUT_EN
//           adds a response timeout with error responses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_arbiter
    import bus_pkg::*;
#(
    parameter int MAX_EXEC_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_req_valid,
    output logic        fetch_req_ready,
    input  logic [31:0] fetch_addr,
    output logic        fetch_resp_valid,
    output logic [31:0] fetch_rdata,
    output logic        fetch_resp_error,
    input  logic        exec_req_valid,
    output logic        exec_req_ready,
    input  logic [31:0] exec_addr,
    input  logic        exec_write,
    input  logic [31:0] exec_wdata,
    input  logic [3:0]  exec_wstrb,
    output logic        exec_resp_valid,
    output logic [31:0] exec_rdata,
    output logic        exec_resp_error,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic        bus_write,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_rdata
);

    localparam logic [3:0] c_STREAK_MAX = 4'(MAX_EXEC_STREAK);

    arb_state_t  state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    bus_req_t    req_q, req_d;
    logic        f_valid_q, f_valid_d, e_valid_q, e_valid_d;
    logic [31:0] f_rdata_q, f_rdata_d, e_rdata_q, e_rdata_d;
    logic        grant_e, grant_f, idle, timeout_hit;

    assign idle    = (state_q == ST_IDLE);
    assign grant_e = exec_req_valid && !(fetch_req_valid && (streak_q == c_STREAK_MAX));
    assign grant_f = fetch_req_valid && !grant_e;

    assign exec_req_ready  = idle && grant_e;
    assign fetch_req_ready = idle && grant_f;

    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        req_d     = req_q;
        f_valid_d = 1'b0;
        f_rdata_d = '0;
        e_valid_d = 1'b0;
        e_rdata_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (!fetch_req_valid || grant_f) begin
                    streak_d = '0;
                end else if (grant_e && (streak_q != c_STREAK_MAX)) begin
                    streak_d = streak_q + 4'd1;
                end
                if (grant_e) begin
                    req_d.addr    = exec_addr;
                    req_d.write   = exec_write;
                    req_d.wdata   = exec_wdata;
                    req_d.wstrb   = exec_wstrb;
                    req_d.is_exec = 1'b1;
                    state_d       = ST_REQ_E;
                end else if (grant_f) begin
                    req_d.addr    = fetch_addr;
                    req_d.write   = 1'b0;
                    req_d.wdata   = '0;
                    req_d.wstrb   = BUS_WSTRB_ALL;
                    req_d.is_exec = 1'b0;
                    state_d       = ST_REQ_F;
                end
            end
            ST_REQ_F, ST_REQ_E: begin
                if (bus_ready) begin
                    state_d = req_q.is_exec ? ST_WAIT_E : ST_WAIT_F;
                end
            end
            ST_WAIT_F: begin
                if (bus_resp_valid) begin
                    f_valid_d = 1'b1;
                    f_rdata_d = bus_rdata;
                    state_d   = ST_IDLE;
                end else if (timeout_hit) begin
                    f_valid_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_WAIT_E: begin
                if (bus_resp_valid) begin
                    e_valid_d = 1'b1;
                    e_rdata_d = req_q.write ? 32'd0 : bus_rdata;
                    state_d   = ST_IDLE;
                end else if (timeout_hit) begin
                    e_valid_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            streak_q  <= '0;
            req_q     <= '0;
            f_valid_q <= 1'b0;
            f_rdata_q <= '0;
            e_valid_q <= 1'b0;
            e_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            req_q     <= req_d;
            f_valid_q <= f_valid_d;
            f_rdata_q <= f_rdata_d;
            e_valid_q <= e_valid_d;
            e_rdata_q <= e_rdata_d;
        end
    end

`ifdef BUS_TIMEOUT_EN
    logic waiting, f_err_q, e_err_q;

    assign waiting = (state_q == ST_WAIT_F) || (state_q == ST_WAIT_E);

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (!waiting),
        .enable_i (waiting),
        .expired_o(timeout_hit)
    );

    // A real response arriving on the expiry cycle wins over the timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            f_err_q <= 1'b0;
            e_err_q <= 1'b0;
        end else begin
            f_err_q <= (state_q == ST_WAIT_F) && !bus_resp_valid && timeout_hit;
            e_err_q <= (state_q == ST_WAIT_E) && !bus_resp_valid && timeout_hit;
        end
    end

    assign fetch_resp_error = f_err_q;
    assign exec_resp_error  = e_err_q;
`else
    assign timeout_hit      = 1'b0;
    assign fetch_resp_error = 1'b0;
    assign exec_resp_error  = 1'b0;
`endif

    assign bus_valid        = (state_q == ST_REQ_F) || (state_q == ST_REQ_E);
    assign bus_addr         = req_q.addr;
    assign bus_write        = req_q.write;
    assign bus_wdata        = req_q.wdata;
    assign bus_wstrb        = req_q.wstrb;
    assign fetch_resp_valid = f_valid_q;
    assign fetch_rdata      = f_rdata_q;
    assign exec_resp_valid  = e_valid_q;
    assign exec_rdata       = e_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module  : tb_bus_arbiter
// Brief   : Directed and randomized self-checking bench for bus_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    localparam int MAXS  = 4;
    localparam int TB_TO = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_req_valid, fetch_req_ready, fetch_resp_valid, fetch_resp_error;
    logic [31:0] fetch_addr, fetch_rdata;
    logic        exec_req_valid, exec_req_ready, exec_write, exec_resp_valid, exec_resp_error;
    logic [31:0] exec_addr, exec_wdata, exec_rdata;
    logic [3:0]  exec_wstrb;
    logic        bus_valid, bus_ready, bus_write, bus_resp_valid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;

    int checks   = 0;
    int failures = 0;

    bus_arbiter #(
        .MAX_EXEC_STREAK(MAXS),
        .TIMEOUT_CYCLES (TB_TO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .fetch_req_valid (fetch_req_valid),
        .fetch_req_ready (fetch_req_ready),
        .fetch_addr      (fetch_addr),
        .fetch_resp_valid(fetch_resp_valid),
        .fetch_rdata     (fetch_rdata),
        .fetch_resp_error(fetch_resp_error),
        .exec_req_valid  (exec_req_valid),
        .exec_req_ready  (exec_req_ready),
        .exec_addr       (exec_addr),
        .exec_write      (exec_write),
        .exec_wdata      (exec_wdata),
        .exec_wstrb      (exec_wstrb),
        .exec_resp_valid (exec_resp_valid),
        .exec_rdata      (exec_rdata),
        .exec_resp_error (exec_resp_error),
        .bus_valid       (bus_valid),
        .bus_ready       (bus_ready),
        .bus_addr        (bus_addr),
        .bus_write       (bus_write),
        .bus_wdata       (bus_wdata),
        .bus_wstrb       (bus_wstrb),
        .bus_resp_valid  (bus_resp_valid),
        .bus_rdata       (bus_rdata)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [67:0] resp_vec();
        return {fetch_resp_valid, fetch_resp_error, fetch_rdata,
                exec_resp_valid, exec_resp_error, exec_rdata};
    endfunction

    // Reference-model state for the random phase
    int          phase, streak, wcnt, n, k;
    logic        ge, gf, acc_e, acc_f;
    logic        cur_exec, cur_write;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_wstrb;
    logic [67:0] exp_r;
    logic [79:0] seqv, seq_exp;

    initial begin
        reset = 1'b1;
        fetch_req_valid = 0; fetch_addr = 0;
        exec_req_valid = 0; exec_addr = 0; exec_write = 0; exec_wdata = 0; exec_wstrb = 0;
        bus_ready = 0; bus_resp_valid = 0; bus_rdata = 0;
        repeat (3) cyc();

        check("reset_bus", {bus_valid, bus_addr, bus_write, bus_wdata, bus_wstrb}, '0);
        check("reset_resp", resp_vec(), '0);
        check("reset_ready", {fetch_req_ready, exec_req_ready}, '0);
        reset = 1'b0;
        cyc();

        // Fetch-only read
        fetch_req_valid = 1; fetch_addr = 32'h100;
        #1;
        check("t1_ready", {fetch_req_ready, exec_req_ready}, 2'b10);
        cyc();
        fetch_req_valid = 0;
        check("t1_bus", {bus_valid, bus_addr, bus_write, bus_wstrb}, {1'b1, 32'h100, 1'b0, 4'hF});
        bus_ready = 1;
        cyc();
        bus_ready = 0; bus_resp_valid = 1; bus_rdata = 32'h00500093;
        check("t1_wait_bus_valid", bus_valid, 1'b0);
        cyc();
        bus_resp_valid = 0;
        check("t1_resp", resp_vec(), {2'b10, 32'h00500093, 34'd0});
        cyc();
        check("t1_pulse_end", resp_vec(), '0);

        // Simultaneous requests: execute first, fetch on the response cycle
        fetch_req_valid = 1; fetch_addr = 32'h104;
        exec_req_valid = 1; exec_addr = 32'h300; exec_write = 0;
        #1;
        check("t2_ready", {fetch_req_ready, exec_req_ready}, 2'b01);
        cyc();
        exec_req_valid = 0;
        #1;
        check("t2_bus_exec", {bus_valid, bus_addr, fetch_req_ready}, {1'b1, 32'h300, 1'b0});
        bus_ready = 1;
        cyc();
        bus_ready = 0; bus_resp_valid = 1; bus_rdata = 32'h11112222;
        cyc();
        bus_resp_valid = 0;
        #1;
        check("t2_exec_resp", resp_vec(), {34'd0, 2'b10, 32'h11112222});
        check("t2_fetch_ready", fetch_req_ready, 1'b1);
        cyc();
        fetch_req_valid = 0;
        check("t2_bus_fetch", {bus_valid, bus_addr}, {1'b1, 32'h104});
        bus_ready = 1;
        cyc();
        bus_ready = 0; bus_resp_valid = 1;
        cyc();
        bus_resp_valid = 0;
        cyc();

        // Both held valid: streak limit interleaves fetch
        seqv = '0; n = 0;
        seq_exp = "EEEEFEEEEF";
        fetch_req_valid = 1; exec_req_valid = 1; exec_write = 0;
        bus_ready = 1; bus_resp_valid = 1;
        for (int i = 0; i < 80 && n < 10; i++) begin
            #1;
            if (fetch_req_ready) begin seqv = {seqv[71:0], 8'h46}; n++; end
            else if (exec_req_ready) begin seqv = {seqv[71:0], 8'h45}; n++; end
            cyc();
        end
        fetch_req_valid = 0; exec_req_valid = 0;
        check("t3_grant_seq", seqv, seq_exp);
        repeat (4) cyc();
        bus_ready = 0; bus_resp_valid = 0;
        cyc();

        // Store with stalled bus_ready
        exec_req_valid = 1; exec_addr = 32'h2000; exec_write = 1;
        exec_wdata = 32'hDEADBEEF; exec_wstrb = 4'b0011;
        cyc();
        exec_req_valid = 0; exec_addr = 32'h5555; exec_wdata = 32'h0; exec_wstrb = 4'hF; exec_write = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) bus_ready = 1;
            #1;
            check("t4_bus_stable", {bus_valid, bus_addr, bus_write, bus_wdata, bus_wstrb},
                  {1'b1, 32'h2000, 1'b1, 32'hDEADBEEF, 4'b0011});
            cyc();
        end
        bus_ready = 0; bus_resp_valid = 1; bus_rdata = 32'hCAFEF00D;
        cyc();
        bus_resp_valid = 0;
        check("t4_store_resp", resp_vec(), {34'd0, 2'b10, 32'd0});
        cyc();

        // Reset while waiting for an execute response
        exec_req_valid = 1; exec_addr = 32'h40;
        cyc();
        exec_req_valid = 0; bus_ready = 1;
        cyc();
        bus_ready = 0; reset = 1;
        cyc();
        reset = 0;
        check("t5_after_reset", {bus_valid, resp_vec(), fetch_req_ready, exec_req_ready}, '0);
        bus_resp_valid = 1; bus_rdata = 32'h77777777;
        cyc();
        bus_resp_valid = 0;
        check("t5_late_resp1", resp_vec(), '0);
        cyc();
        check("t5_late_resp2", resp_vec(), '0);

`ifdef BUS_TIMEOUT_EN
        // No response: timeout error after TB_TO wait cycles
        fetch_req_valid = 1; fetch_addr = 32'h800;
        cyc();
        fetch_req_valid = 0; bus_ready = 1;
        cyc();
        bus_ready = 0; k = 0;
        while (k < 40 && !fetch_resp_valid) begin cyc(); k++; end
        check("t6_timeout_cycles", k, TB_TO);
        check("t6_timeout_resp", resp_vec(), {2'b11, 32'd0, 34'd0});
        fetch_req_valid = 1; fetch_addr = 32'h804;
        #1;
        check("t6_idle_again", fetch_req_ready, 1'b1);
        cyc();
        fetch_req_valid = 0; bus_ready = 1;
        cyc();
        bus_ready = 0; bus_resp_valid = 1; bus_rdata = 32'h1234;
        cyc();
        bus_resp_valid = 0;
        cyc();
`endif

        // Randomized traffic against the reference model
        phase = 0; streak = 0; wcnt = 0; acc_e = 0; acc_f = 0; exp_r = '0;
        cur_exec = 0; cur_write = 0; cur_addr = 0; cur_wdata = 0; cur_wstrb = 0;
        for (int c = 0; c < 3000; c++) begin
            if (acc_e) exec_req_valid = 0;
            if (acc_f) fetch_req_valid = 0;
            if (!fetch_req_valid && $urandom_range(0, 9) < 4) begin
                fetch_req_valid = 1; fetch_addr = $urandom() & 32'hFFFF_FFFC;
            end
            if (!exec_req_valid && $urandom_range(0, 9) < 4) begin
                exec_req_valid = 1; exec_addr = $urandom(); exec_write = 1'($urandom_range(0, 1));
                exec_wdata = $urandom(); exec_wstrb = 4'($urandom_range(0, 15));
            end
            bus_ready      = 1'($urandom_range(0, 1));
            bus_resp_valid = (phase == 2) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) == 0);
            bus_rdata      = $urandom();
            #1;
            ge = (phase == 0) && exec_req_valid && !(fetch_req_valid && streak == MAXS);
            gf = (phase == 0) && fetch_req_valid && !ge;
            check("rand_resp", resp_vec(), exp_r);
            check("rand_ready", {fetch_req_ready, exec_req_ready}, {gf, ge});
            check("rand_bus_valid", bus_valid, phase == 1);
            if (phase == 1)
                check("rand_bus_req", {bus_addr, bus_write, bus_wdata, bus_wstrb},
                      {cur_addr, cur_write, cur_wdata, cur_wstrb});
            acc_e = ge; acc_f = gf; exp_r = '0;
            if (phase == 0) begin
                if (ge) begin
                    cur_exec = 1; cur_addr = exec_addr; cur_write = exec_write;
                    cur_wdata = exec_wdata; cur_wstrb = exec_wstrb; phase = 1;
                    streak = fetch_req_valid ? ((streak < MAXS) ? streak + 1 : streak) : 0;
                end else if (gf) begin
                    cur_exec = 0; cur_addr = fetch_addr; cur_write = 0;
                    cur_wdata = 0; cur_wstrb = 4'hF; phase = 1; streak = 0;
                end else begin
                    streak = 0;
                end
            end else if (phase == 1) begin
                if (bus_ready) begin phase = 2; wcnt = 0; end
            end else begin
                if (bus_resp_valid) begin
                    if (cur_exec) exp_r = {34'd0, 2'b10, cur_write ? 32'd0 : bus_rdata};
                    else          exp_r = {2'b10, bus_rdata, 34'd0};
                    phase = 0;
                end else begin
                    wcnt++;
`ifdef BUS_TIMEOUT_EN
                    if (wcnt == TB_TO) begin
                        exp_r = cur_exec ? {34'd0, 2'b11, 32'd0} : {2'b11, 32'd0, 34'd0};
                        phase = 0;
                    end
`endif
                end
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
